stage_id: RTL and testbench

//  Decode-side consumer of the fetch stage. Holds the IF/ID pipeline register fed by IR_F/PCInc4_F.

---
 rtl/stage_id.sv | 113 +++++++++++
 tb/tb_stage_id.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_id.sv
// Decode stage: IF/ID pipeline register, branch/jump resolution driving the
// fetch redirect, and a saturating counter of taken redirects.
module stage_id #(
  parameter logic [31:0] RESET_PC = 32'h0000_3004,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_D,
  input  logic             flush_D,
  input  logic [31:0]      IR_F,
  input  logic [31:0]      PCInc4_F,
  input  logic [31:0]      RD1_D,
  input  logic [31:0]      RD2_D,
  output logic [31:0]      IR_D,
  output logic [31:0]      PCInc4_D,
  output logic [4:0]       rs_D,
  output logic [4:0]       rt_D,
  output logic             ctrl_pc_src_D,
  output logic [31:0]      NPC_D,
  output logic             link_D,
  output logic [CNT_W-1:0] taken_cnt
);

  logic [31:0]      ir_q, ir_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] brTarget;
  logic [31:0] jTarget;
  logic [31:0] target;
  logic        taken;
  logic        rsNeg;
  logic        rsZero;

  // Flush beats stall; the counter samples the redirect seen before the edge.
  always_comb begin
    ir_d  = ir_q;
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (flush_D) begin
      ir_d = '0;
      pc_d = PCInc4_F;
    end else if (!stall_D) begin
      ir_d = IR_F;
      pc_d = PCInc4_F;
    end
    if (ctrl_pc_src_D && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q  <= '0;
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      ir_q  <= ir_d;
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign op       = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign rsNeg    = RD1_D[31];
  assign rsZero   = (RD1_D == 32'h0);
  assign brTarget = pc_q + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign jTarget  = {pc_q[31:28], ir_q[25:0], 2'b00};

  // Signed compares against zero reduce to sign bit and zero test.
  always_comb begin
    taken  = 1'b0;
    target = brTarget;
    case (op)
      6'd1: begin
        if (ir_q[20:16] == 5'd0) begin
          taken = rsNeg;
        end else if (ir_q[20:16] == 5'd1) begin
          taken = !rsNeg;
        end
      end
      6'd4: taken = (RD1_D == RD2_D);
      6'd5: taken = (RD1_D != RD2_D);
      6'd6: taken = rsNeg || rsZero;
      6'd7: taken = !rsNeg && !rsZero;
      6'd2, 6'd3: begin
        taken  = 1'b1;
        target = jTarget;
      end
      6'd0: begin
        if ((funct == 6'd8) || (funct == 6'd9)) begin
          taken  = 1'b1;
          target = RD1_D;
        end
      end
      default: taken = 1'b0;
    endcase
  end

  assign IR_D          = ir_q;
  assign PCInc4_D      = pc_q;
  assign rs_D          = ir_q[25:21];
  assign rt_D          = ir_q[20:16];
  assign ctrl_pc_src_D = taken & ~stall_D;
  assign NPC_D         = taken ? target : pc_q;
  assign link_D        = (op == 6'd3) || ((op == 6'd0) && (funct == 6'd9));
  assign taken_cnt     = cnt_q;

endmodule

// File: tb/tb_stage_id.sv
// Scoreboard bench for stage_id: a behavioural model predicts each cycle's
// decode outputs, a negedge monitor pops and compares them.
module tb_stage_id;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_D, flush_D;
  logic [31:0] IR_F, PCInc4_F, RD1_D, RD2_D;

  logic [31:0] IR_D, PCInc4_D, NPC_D;
  logic [4:0]  rs_D, rt_D;
  logic        ctrl_pc_src_D, link_D;
  logic [31:0] taken_cnt;

  logic [31:0] IR_D4, PCInc4_D4, NPC_D4;
  logic [4:0]  rs_D4, rt_D4;
  logic        src4, link4;
  logic [3:0]  taken_cnt4;

  always #5 clk = ~clk;

  stage_id dut (
    .clk(clk), .rst(rst), .stall_D(stall_D), .flush_D(flush_D),
    .IR_F(IR_F), .PCInc4_F(PCInc4_F), .RD1_D(RD1_D), .RD2_D(RD2_D),
    .IR_D(IR_D), .PCInc4_D(PCInc4_D), .rs_D(rs_D), .rt_D(rt_D),
    .ctrl_pc_src_D(ctrl_pc_src_D), .NPC_D(NPC_D), .link_D(link_D),
    .taken_cnt(taken_cnt)
  );

  stage_id #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall_D(stall_D), .flush_D(flush_D),
    .IR_F(IR_F), .PCInc4_F(PCInc4_F), .RD1_D(RD1_D), .RD2_D(RD2_D),
    .IR_D(IR_D4), .PCInc4_D(PCInc4_D4), .rs_D(rs_D4), .rt_D(rt_D4),
    .ctrl_pc_src_D(src4), .NPC_D(NPC_D4), .link_D(link4),
    .taken_cnt(taken_cnt4)
  );

  typedef struct {
    logic [31:0] ir, pc, npc, cnt;
    logic [4:0]  rs, rt;
    logic        src, link;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t        sbQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mIr, mPc, mCnt;
  int          mCnt4;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Architectural meaning of each branch/jump, written from the ISA rules.
  function automatic void refDecode(input logic [31:0] ir, pc, a, b,
                                    output logic tk, output logic [31:0] tgt);
    logic signed [31:0] sa;
    logic signed [31:0] off;
    int op, fn, rtf;
    sa  = a;
    off = $signed(ir[15:0]);
    off = off * 4;
    op  = int'(ir >> 26);
    fn  = int'(ir & 32'h3F);
    rtf = int'((ir >> 16) & 32'h1F);
    tk  = 1'b0;
    tgt = pc + off;
    if (op == 4) tk = (a == b);
    else if (op == 5) tk = (a != b);
    else if (op == 6) tk = (sa <= 0);
    else if (op == 7) tk = (sa > 0);
    else if (op == 1 && rtf == 0) tk = (sa < 0);
    else if (op == 1 && rtf == 1) tk = (sa >= 0);
    else if (op == 2 || op == 3) begin
      tk  = 1'b1;
      tgt = (pc & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
    end else if (op == 0 && (fn == 8 || fn == 9)) begin
      tk  = 1'b1;
      tgt = a;
    end
  endfunction

  function automatic exp_t expectNow();
    exp_t        e;
    logic        tk;
    logic [31:0] tgt;
    refDecode(mIr, mPc, RD1_D, RD2_D, tk, tgt);
    e.ir   = mIr;
    e.pc   = mPc;
    e.rs   = mIr[25:21];
    e.rt   = mIr[20:16];
    e.src  = tk && !stall_D;
    e.npc  = tk ? tgt : mPc;
    e.link = (mIr[31:26] == 6'd3) || (mIr[31:26] == 6'd0 && mIr[5:0] == 6'd9);
    e.cnt  = mCnt;
    e.cnt4 = 4'(mCnt4);
    return e;
  endfunction

  task automatic modelReset();
    mIr   = 32'h0;
    mPc   = 32'h0000_3004;
    mCnt  = 32'h0;
    mCnt4 = 0;
  endtask

  task automatic modelEdge();
    exp_t e;
    e = expectNow();
    if (e.src) begin
      if (mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 1;
      if (mCnt4 < 15) mCnt4 = mCnt4 + 1;
    end
    if (flush_D) begin
      mIr = 32'h0;
      mPc = PCInc4_F;
    end else if (!stall_D) begin
      mIr = IR_F;
      mPc = PCInc4_F;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ir, pc, a, b, input logic st, fl);
    @(posedge clk);
    modelEdge();
    #1;
    IR_F     = ir;
    PCInc4_F = pc;
    RD1_D    = a;
    RD2_D    = b;
    stall_D  = st;
    flush_D  = fl;
    sbQ.push_back(expectNow());
  endtask

  task automatic checkOutput(input exp_t e);
    check32("IR_D", IR_D, e.ir);
    check32("PCInc4_D", PCInc4_D, e.pc);
    check32("rs_D", {27'h0, rs_D}, {27'h0, e.rs});
    check32("rt_D", {27'h0, rt_D}, {27'h0, e.rt});
    check32("ctrl_pc_src_D", {31'h0, ctrl_pc_src_D}, {31'h0, e.src});
    check32("NPC_D", NPC_D, e.npc);
    check32("link_D", {31'h0, link_D}, {31'h0, e.link});
    check32("taken_cnt", taken_cnt, e.cnt);
    check32("taken_cnt4", {28'h0, taken_cnt4}, {28'h0, e.cnt4});
    check32("NPC_D4", NPC_D4, e.npc);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput(e);
    end
  end

  task automatic checkReset(input string tag);
    check32({tag, "_IR_D"}, IR_D, 32'h0);
    check32({tag, "_PCInc4_D"}, PCInc4_D, 32'h0000_3004);
    check32({tag, "_src"}, {31'h0, ctrl_pc_src_D}, 32'h0);
    check32({tag, "_link"}, {31'h0, link_D}, 32'h0);
    check32({tag, "_cnt"}, taken_cnt, 32'h0);
    check32({tag, "_cnt4"}, {28'h0, taken_cnt4}, 32'h0);
  endtask

  task automatic resetPulse();
    @(negedge clk);
    #1 rst = 1'b1;
    #1 checkReset("midReset");
    #1 rst = 1'b0;
    modelReset();
  endtask

  function automatic logic [31:0] randIr();
    logic [31:0] ir;
    int sel;
    ir  = $urandom();
    sel = $urandom_range(0, 10);
    if (sel <= 7) ir[31:26] = 6'(sel);
    if (sel == 10) ir = 32'h0;
    if (ir[31:26] == 6'd0 && $urandom_range(0, 2) != 0) ir[5:0] = ($urandom_range(0, 1) != 0) ? 6'd8 : 6'd9;
    if (ir[31:26] == 6'd1 && $urandom_range(0, 3) != 0) ir[20:16] = 5'($urandom_range(0, 1));
    return ir;
  endfunction

  function automatic logic [31:0] randVal();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    rst      = 1'b1;
    stall_D  = 1'b0;
    flush_D  = 1'b0;
    IR_F     = 32'h0;
    PCInc4_F = 32'h0000_3008;
    RD1_D    = 32'h0;
    RD2_D    = 32'h0;
    modelReset();
    #1 checkReset("initReset");
    #1 rst = 1'b0;

    // beq $1,$2,-1: equal operands redirect back to 0x3004, unequal fall through
    applyStimulus(32'h1022FFFF, 32'h3008, 0, 0, 0, 0);
    applyStimulus(32'h1022FFFF, 32'h3008, 5, 5, 0, 0);
    #1 check32("beq_src", {31'h0, ctrl_pc_src_D}, 32'h1);
    check32("beq_npc", NPC_D, 32'h3004);
    applyStimulus(32'h0, 32'h300C, 5, 6, 0, 0);
    #1 check32("bne_case_src", {31'h0, ctrl_pc_src_D}, 32'h0);
    check32("bne_case_npc", NPC_D, 32'h3008);

    // j / jal 0x0C01
    applyStimulus(32'h08000C01, 32'h3010, 0, 0, 0, 0);
    applyStimulus(32'h0C000C01, 32'h3010, 0, 0, 0, 0);
    #1 check32("j_npc", NPC_D, 32'h3004);
    check32("j_link", {31'h0, link_D}, 32'h0);
    applyStimulus(32'h0, 32'h3014, 0, 0, 0, 0);
    #1 check32("jal_npc", NPC_D, 32'h3004);
    check32("jal_link", {31'h0, link_D}, 32'h1);

    // jr $31 held by three stalled edges, redirects once released
    applyStimulus(32'h03E00008, 32'h3020, 0, 0, 0, 0);
    applyStimulus(32'h0, 32'h3024, 32'h3100, 0, 1, 0);
    #1 check32("jr_stall_src", {31'h0, ctrl_pc_src_D}, 32'h0);
    applyStimulus(32'h0, 32'h3028, 32'h3100, 0, 1, 0);
    applyStimulus(32'h0, 32'h302C, 32'h3100, 0, 1, 0);
    applyStimulus(32'h0, 32'h3030, 32'h3100, 0, 0, 0);
    #1 check32("jr_held_ir", IR_D, 32'h03E00008);
    check32("jr_src", {31'h0, ctrl_pc_src_D}, 32'h1);
    check32("jr_npc", NPC_D, 32'h3100);

    // sign-sensitive branches at their zero boundaries
    applyStimulus(32'h04210004, 32'h3040, 0, 0, 0, 0);
    applyStimulus(32'h04210004, 32'h3040, 32'hFFFF_FFFF, 0, 0, 0);
    #1 check32("bgez_neg_src", {31'h0, ctrl_pc_src_D}, 32'h0);
    applyStimulus(32'h1C200004, 32'h3044, 0, 0, 0, 0);
    #1 check32("bgez_zero_src", {31'h0, ctrl_pc_src_D}, 32'h1);
    check32("bgez_zero_npc", NPC_D, 32'h3050);
    applyStimulus(32'h18200004, 32'h3048, 0, 0, 0, 0);
    #1 check32("bgtz_zero_src", {31'h0, ctrl_pc_src_D}, 32'h0);
    applyStimulus(32'h0, 32'h304C, 32'h8000_0000, 0, 0, 0);
    #1 check32("blez_min_src", {31'h0, ctrl_pc_src_D}, 32'h1);
    check32("blez_min_npc", NPC_D, 32'h3058);

    // flush and stall together, then a run of jumps to saturate the small counter
    applyStimulus(32'h08000C01, 32'h3060, 0, 0, 0, 0);
    applyStimulus(32'h0, 32'h3064, 0, 0, 1, 1);
    applyStimulus(32'h08000C01, 32'h3068, 0, 0, 0, 0);
    #1 check32("flush_ir", IR_D, 32'h0);
    check32("flush_pc", PCInc4_D, 32'h3064);
    for (int i = 0; i < 20; i++) applyStimulus(32'h08000C01, 32'h3070, 0, 0, 0, 0);
    #1 check32("cnt4_saturated", {28'h0, taken_cnt4}, 32'hF);

    // randomized traffic with a mid-run reset
    for (int i = 0; i < 600; i++) begin
      a = randVal();
      applyStimulus(randIr(), $urandom(), a, ($urandom_range(0, 1) != 0) ? a : randVal(),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      if (i == 300) resetPulse();
    end

    repeat (2) @(negedge clk);
    #1 check32("scoreboard_drained", sbQ.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
